// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory / MMIO responder: I/O page layout and STATUS bits.
package dmem_mmio_responder_pkg;

    localparam int unsigned DATA_W = 32;

    // Base of the 256-byte I/O page.
    localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;

    // Byte offsets within the I/O page.
    localparam logic [7:0] IO_CYCLE   = 8'h00;
    localparam logic [7:0] IO_TXDATA  = 8'h04;
    localparam logic [7:0] IO_STATUS  = 8'h08;
    localparam logic [7:0] IO_TXCOUNT = 8'h0C;

    // STATUS register bit positions.
    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_CNT_LSB = 2;
    localparam int unsigned ST_OVF     = 8;

    // Word index of an I/O offset (byte lane bits dropped).
    function automatic logic [5:0] io_word(input logic [7:0] off);
        return off[7:2];
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Transmit FIFO: registered storage, head presented on dout_o, zero when empty.
// A push while full is accepted only if a pop happens in the same cycle.
module dmem_mmio_responder_tx_fifo #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [DATA_W-1:0]  din_i,
    input  logic               pop_i,
    output logic [DATA_W-1:0]  dout_o,
    output logic               empty_o,
    output logic               full_o,
    output logic [FIFO_AW:0]   count_o
);

    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

    logic [DATA_W-1:0]  mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DepthCnt);
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Accept/pop decisions and next pointer/occupancy values.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (FIFO_AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (FIFO_AW + 1)'(1);
        end
    end

    // Pointer and occupancy state; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; on a full push+pop the slot being written is the one just popped.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: word RAM plus an I/O page with a cycle counter,
// a transmit FIFO draining to a valid/ready stream, and status/count registers.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int unsigned DATA_W  = dmem_mmio_responder_pkg::DATA_W,
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned FIFO_AW = 2,
    parameter logic [DATA_W-1:0] IO_BASE = dmem_mmio_responder_pkg::IO_BASE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  addr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic               we_i,
    output logic [DATA_W-1:0]  rdata_o,
    output logic               tx_valid_o,
    output logic [DATA_W-1:0]  tx_data_o,
    input  logic               tx_ready_i
);

    localparam int unsigned CntW = FIFO_AW + 1;
    localparam logic [5:0] WCycle   = io_word(IO_CYCLE);
    localparam logic [5:0] WTxData  = io_word(IO_TXDATA);
    localparam logic [5:0] WStatus  = io_word(IO_STATUS);
    localparam logic [5:0] WTxCount = io_word(IO_TXCOUNT);

    logic [DATA_W-1:0] ram_q [2**RAM_AW];
    logic [DATA_W-1:0] cycle_q, cycle_d;
    logic [DATA_W-1:0] tx_count_q, tx_count_d;
    logic              ovf_q, ovf_d;

    logic              ram_hit, io_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic [5:0]        io_sel;
    logic              push, pop, clr_ovf;
    logic              fifo_empty, fifo_full;
    logic [FIFO_AW:0]  fifo_count;
    logic [DATA_W-1:0] fifo_dout;
    logic [DATA_W-1:0] status;
    logic              unused_addr;

    // Byte-lane bits are ignored: all accesses are whole words.
    assign unused_addr = ^addr_i[1:0];

    assign ram_hit = (addr_i[DATA_W-1:RAM_AW+2] == '0);
    assign io_hit  = (addr_i[DATA_W-1:8] == IO_BASE[DATA_W-1:8]);
    assign ram_idx = addr_i[RAM_AW+1:2];
    assign io_sel  = addr_i[7:2];

    assign push    = we_i & io_hit & (io_sel == WTxData);
    assign clr_ovf = we_i & io_hit & (io_sel == WStatus) & wdata_i[ST_OVF];
    assign pop     = tx_valid_o & tx_ready_i;

    assign tx_valid_o = ~fifo_empty;
    assign tx_data_o  = fifo_dout;

    dmem_mmio_responder_tx_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (wdata_i),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Next values for the counters and the sticky overflow flag (set beats clear).
    always_comb begin
        cycle_d    = cycle_q + DATA_W'(1);
        tx_count_d = tx_count_q + (pop ? DATA_W'(1) : '0);
        ovf_d      = ovf_q & ~clr_ovf;
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Counter and flag state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q    <= '0;
            tx_count_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            tx_count_q <= tx_count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Word RAM; contents survive reset, and a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (we_i && ram_hit) begin
            ram_q[ram_idx] <= wdata_i;
        end
    end

    // STATUS image.
    always_comb begin
        status                        = '0;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_FULL]               = fifo_full;
        status[ST_CNT_LSB +: CntW]    = fifo_count;
        status[ST_OVF]                = ovf_q;
    end

    // Combinational load mux.
    always_comb begin
        rdata_o = '0;
        if (ram_hit) begin
            rdata_o = ram_q[ram_idx];
        end else if (io_hit) begin
            case (io_sel)
                WCycle:   rdata_o = cycle_q;
                WStatus:  rdata_o = status;
                WTxCount: rdata_o = tx_count_q;
                default:  rdata_o = '0;
            endcase
        end
    end

endmodule
